// File: rtl/cmp2_share_arbiter.sv
// Two-requester round-robin front end sharing one serial 2-bit magnitude
// comparator; one job in flight, result held in a single-entry response register.
module cmp2_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_lt,
    output logic             rsp_eq,
    output logic             rsp_gt,
    output logic             busy
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             id_q;
    logic             last_grant_q;
    logic             rsp_valid_q, rsp_id_q, rsp_lt_q, rsp_eq_q, rsp_gt_q;
    logic             busy_q;

    logic             grant;
    logic             take;
    logic [1:0]       a_dig [DIGITS];
    logic [1:0]       b_dig [DIGITS];
    logic [1:0]       cur_a, cur_b;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign grant      = req1_valid && (!req0_valid || !last_grant_q);
    assign take       = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign a_dig[gi] = a_q[2*gi +: 2];
            assign b_dig[gi] = b_q[2*gi +: 2];
        end
    endgenerate

    assign cur_a = a_dig[idx_q];
    assign cur_b = b_dig[idx_q];
    assign idx_d = idx_q - IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= IDX_TOP;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        idx_q        <= IDX_TOP;
                        busy_q       <= 1'b1;
                        state_q      <= CMP;
                    end
                end
                CMP: begin
                    // MSB digit first; the first unequal digit settles the result.
                    if (cur_a > cur_b) begin
                        rsp_gt_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        state_q     <= RESP;
                    end else if (cur_a < cur_b) begin
                        rsp_lt_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        state_q     <= RESP;
                    end else if (idx_q == '0) begin
                        rsp_eq_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        state_q     <= RESP;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_id_q    <= 1'b0;
                        rsp_lt_q    <= 1'b0;
                        rsp_eq_q    <= 1'b0;
                        rsp_gt_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_gt    = rsp_gt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_cmp2_share_arbiter.sv
// Directed plus random checks of cmp2_share_arbiter against a transaction-level
// model: arithmetic compare, first-differing-digit latency, round-robin grant.
module tb_cmp2_share_arbiter;
    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_lt, rsp_eq, rsp_gt, busy;

    int total = 0;
    int bad   = 0;
    bit model_lg;

    cmp2_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digits examined = position of the first differing 2-bit digit counted from the MSB.
    function automatic int digits_examined(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int d = DIGITS - 1; d >= 0; d--)
            if (((a >> (2 * d)) & 3) != ((b >> (2 * d)) & 3)) return DIGITS - d;
        return DIGITS;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, rsp_valid, 1'b0);
        check({tag, "_flags"}, {rsp_id, rsp_lt, rsp_eq, rsp_gt}, 4'b0);
    endtask

    // Entered and left on a negedge with the DUT idle.
    task automatic job(input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                       input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                       input int stall, input bit keep);
        bit exp_id;
        logic [WIDTH-1:0] ea, eb;
        int k;
        logic [2:0] exp_f;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b0;
        exp_id = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : !model_lg;
        #1;
        check("ready0", req0_ready, v0 && exp_id == 1'b0);
        check("ready1", req1_ready, v1 && exp_id == 1'b1);
        check("busy_idle", busy, 1'b0);
        @(posedge clk);
        model_lg = exp_id;
        ea = exp_id ? a1 : a0;
        eb = exp_id ? b1 : b0;
        k = digits_examined(ea, eb);
        exp_f = {ea < eb, ea == eb, ea > eb};
        $display("txn id=%0d a=%02h b=%02h k=%0d lt/eq/gt=%03b stall=%0d", exp_id, ea, eb, k, exp_f, stall);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
                req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
                if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
            #1;
            check_quiet("cmp");
            check("busy_cmp", busy, 1'b1);
            check("ready_cmp", {req0_ready, req1_ready}, 2'b00);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            #1;
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_id", rsp_id, exp_id);
            check("rsp_flags", {rsp_lt, rsp_eq, rsp_gt}, exp_f);
            check("ready_resp", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check_quiet("after_hs");
        check("busy_after_hs", busy, 1'b0);
    endtask

    initial begin
        bit rv0, rv1;
        logic [WIDTH-1:0] ra0, rb0, ra1, rb1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        model_lg = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        job(1, 8'hA5, 8'hA5, 0, 8'h00, 8'h00, 0, 0);   // equal, full latency
        job(0, 8'h00, 8'h00, 1, 8'hC0, 8'h40, 0, 0);   // MSB digit decides
        job(1, 8'h12, 8'h13, 0, 8'h00, 8'h00, 0, 0);   // LSB digit decides

        // Contention right after reset: expect grant order 0,1,0,1.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_lg = 1'b1;
        for (int j = 0; j < 4; j++) job(1, 8'h3C, 8'h3D, 1, 8'hF0, 8'h0F, 0, 1);
        // Backpressure with both requesters waiting.
        job(1, 8'h55, 8'h54, 1, 8'h01, 8'h80, 5, 1);
        job(1, 8'h55, 8'h54, 1, 8'h01, 8'h80, 0, 0);

        // Reset in the middle of a compare.
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h13;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_lg = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check_quiet("no_orphan");
        end
        @(negedge clk);
        job(1, 8'h81, 8'h80, 1, 8'h00, 8'hFF, 1, 0);   // req0 must win first contention

        for (int j = 0; j < 30; j++) begin
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            ra0 = WIDTH'($urandom); ra1 = WIDTH'($urandom);
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : (ra0 ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)));
            rb1 = ($urandom_range(0, 3) == 0) ? ra1 : WIDTH'($urandom);
            job(rv0, ra0, rb0, rv1, ra1, rb1, $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
